// File: rtl/adder_64.sv
// adder_64: registered 64-bit adder (16 rippled 4-bit CLA groups) with carry-in.
// Define ADDER_FLAGS_EN to add registered c_out and ovf flags.
module adder_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        out_valid
`ifdef ADDER_FLAGS_EN
  ,
  output logic        c_out,
  output logic        ovf
`endif
);
  localparam int WIDTH = 64;
  logic [WIDTH-1:0] p, g, sum_d, sum_q;
  logic [WIDTH:0]   c;
  logic             valid_q;
  assign p = a ^ b;
  assign g = a & b;
  // Lookahead inside each 4-bit group; the group carry-out ripples to the next group.
  always_comb begin
    c = '0;
    c[0] = c_in;
    for (int k = 0; k < WIDTH / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end
  assign sum_d = p ^ c[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) sum_q <= sum_d;
    end
  end
  assign sum       = sum_q;
  assign out_valid = valid_q;
`ifdef ADDER_FLAGS_EN
  logic c_out_q, ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_valid) begin
      c_out_q <= c[WIDTH];
      ovf_q   <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_adder_64.sv
// tb_adder_64: directed vectors for adder_64 checked against an arithmetic model every cycle.
module tb_adder_64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic [63:0] sum;
  logic        out_valid;
  int total = 0, bad = 0;
`ifdef ADDER_FLAGS_EN
  logic c_out, ovf;
  adder_64 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
                .sum(sum), .out_valid(out_valid), .c_out(c_out), .ovf(ovf));
`else
  adder_64 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
                .sum(sum), .out_valid(out_valid));
`endif
  always #5 clk = ~clk;

  // Model: plain 65-bit arithmetic, signed overflow from operand/result signs.
  logic [63:0] m_sum;
  logic        m_valid, m_c, m_o;
  logic [64:0] full;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= '0; m_valid <= 1'b0; m_c <= 1'b0; m_o <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        full = {1'b0, a} + {1'b0, b} + {64'd0, c_in};
        m_sum <= full[63:0];
        m_c   <= full[64];
        m_o   <= (a[63] == b[63]) && (full[63] != a[63]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("cyc_sum", sum, m_sum);
`ifdef ADDER_FLAGS_EN
    check("cyc_cout", {63'd0, c_out}, {63'd0, m_c});
    check("cyc_ovf", {63'd0, ovf}, {63'd0, m_o});
`endif
  end

  task automatic drive(input logic [63:0] va, input logic [63:0] vb, input logic vc, input logic v);
    @(negedge clk);
    a = va; b = vb; c_in = vc; in_valid = v;
  endtask

  // One valid vector, then literal checks of DUT and model one edge later.
  task automatic vec(input string name, input logic [63:0] va, input logic [63:0] vb, input logic vc,
                     input logic [63:0] es, input logic ec, input logic eo);
    drive(va, vb, vc, 1'b1);
    @(posedge clk); #1;
    check({name, "_sum"}, sum, es);
    check({name, "_vld"}, {63'd0, out_valid}, 64'd1);
    check({name, "_msum"}, m_sum, es);
    check({name, "_mc"}, {63'd0, m_c}, {63'd0, ec});
    check({name, "_mo"}, {63'd0, m_o}, {63'd0, eo});
`ifdef ADDER_FLAGS_EN
    check({name, "_cout"}, {63'd0, c_out}, {63'd0, ec});
    check({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
`endif
  endtask

  initial begin
    #12;
    check("rst_sum", sum, 64'd0);
    check("rst_vld", {63'd0, out_valid}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    vec("zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    vec("small", 64'd3, 64'd4, 1'b1, 64'd8, 1'b0, 1'b0);
    vec("swrap1", 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000, 1'b1, 64'hFFFFFFFF_00000001, 1'b1, 1'b0);
    vec("swrap0", 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000, 1'b0, 64'hFFFFFFFF_00000000, 1'b1, 1'b0);
    vec("b32_0", 64'd2147483648, 64'd2147483647, 1'b0, 64'h00000000_FFFFFFFF, 1'b0, 1'b0);
    vec("b32_1", 64'd2147483648, 64'd2147483647, 1'b1, 64'h00000001_00000000, 1'b0, 1'b0);
    vec("wrap64", 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    vec("mixed", -64'sd58654565, 64'd7777777, 1'b1, -64'sd50876787, 1'b0, 1'b0);
    vec("ovf", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1);
    // Idle with toggling operands: outputs must hold.
    for (int i = 0; i < 4; i++) drive(64'h1234 * (i + 1), 64'hFFFF_0000 ^ i, i[0], 1'b0);
    @(posedge clk); #1;
    check("hold_sum", sum, 64'h80000000_00000000);
    check("hold_vld", {63'd0, out_valid}, 64'd0);
    // Back-to-back stream.
    vec("bb0", 64'd100, 64'd200, 1'b0, 64'd300, 1'b0, 1'b0);
    vec("bb1", 64'hFFFF_FFFF, 64'd1, 1'b0, 64'h1_0000_0000, 1'b0, 1'b0);
    vec("bb2", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);
    vec("bb3", 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 64'd0, 1'b1, 1'b0);
    // Asynchronous reset mid-stream while a result is valid.
    vec("pre_rst", 64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", sum, 64'd0);
    check("arst_vld", {63'd0, out_valid}, 64'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_vld", {63'd0, out_valid}, 64'd0);
    vec("after", 64'd40, 64'd2, 1'b0, 64'd42, 1'b0, 1'b0);
    drive(64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_64.md
# adder_64

Registered 64-bit two's-complement/unsigned adder with carry-in, the integer add datapath of the ALU. Computes a + b + c_in modulo 2^64 and presents the sum one clock after the operands are sampled. It sits between the ALU operand muxes and the result writeback mux. An optional build-time feature adds carry-out and signed-overflow flags.

## Interface
- Reset is asynchronous and active-low; one clock.
- WIDTH, 64, operand/sum width. Fixed at 64; other values are unsupported.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  64  operand A, unsigned or two's complement
- b  input  64  operand B, unsigned or two's complement
- c_in  input  1  carry-in, weight 1
- sum  output  64  registered (a + b + c_in) mod 2^64
- out_valid  output  1  sum holds a new result this cycle
- c_out  output  1  carry out of bit 63; present only with ADDER_FLAGS_EN
- ovf  output  1  signed overflow; present only with ADDER_FLAGS_EN

## Operation
- Datapath: 16 groups of 4-bit carry-lookahead. Each group uses generate g = a&b and propagate p = a^b.
  - Group carries ripple group-to-group, starting from c_in.
  - Group sum bit i is p[i] ^ carry[i].
- Raw result: sum_next = a + b + c_in truncated to 64 bits. There is no saturation.
  - Wrap-around is silent: all-ones + 0 + 1 gives 0.
- c_out is carry[64].
  - It flags an unsigned overflow.
- ovf is carry[64] ^ carry[63], which is true when both operands have the same sign and the result sign differs.
  - It flags a signed overflow.
- Signed and unsigned inputs share identical logic. Signedness only changes how sum and the flags are interpreted.
- When in_valid=1 on a rising edge, sum (and the flags) are loaded with sum_next.
- When in_valid=0 on a rising edge, sum and the flags hold their previous value.
- out_valid is a registered copy of in_valid.
- There is no backpressure: every valid input produces exactly one output pulse.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on sum at edge N, with out_valid=1 during cycle N+1.
- Throughput is 1 result per cycle; back-to-back in_valid is supported.
- The combinational path a/b/c_in → sum_next must close within one clk period.
- Reset values: sum=0, out_valid=0, c_out=0, ovf=0.
- Reset takes effect immediately when rst_n falls, independent of clk.
- Reset mid-operation: any result in flight is discarded. The first valid result after release needs in_valid=1 on an edge with rst_n=1.
- Inputs that change while in_valid=0 have no effect on the outputs.

## Configuration
- ADDER_FLAGS_EN defined:
  - c_out and ovf ports exist.
  - Both are registered alongside sum with the same latency and reset value 0.
- ADDER_FLAGS_EN undefined:
  - Neither port exists and no flag registers are built.
  - sum and out_valid behaviour is unchanged.

## Test plan
- Zero case: a=0, b=0, c_in=0, in_valid=1 → next cycle sum=0, out_valid=1, c_out=0, ovf=0.
- Small operands: a=3, b=4, c_in=1 → sum=8.
- Signed wrap: a=b=0xFFFFFFFF_80000000 (-2147483648), c_in=1 → sum=0xFFFFFFFF_00000001 (-4294967295), c_out=1, ovf=0.
  - Repeat with c_in=0 → sum=0xFFFFFFFF_00000000 (-4294967296).
- 32-bit boundary: a=2147483648, b=2147483647, c_in=0 → sum=0x00000000_FFFFFFFF.
  - Repeat with c_in=1 → sum=0x00000001_00000000, carried into bit 32.
- 64-bit wrap and mixed signs:
  - a=0xFFFFFFFF_FFFFFFFF, b=0, c_in=1 → sum=0, c_out=1, ovf=0.
  - a=-58654565, b=7777777, c_in=1 → sum=-50876787 (two's complement), c_out=0.
  - a=0x7FFFFFFF_FFFFFFFF, b=1, c_in=0 → sum=0x80000000_00000000, ovf=1.
- Control:
  - Hold in_valid=0 while toggling a/b → sum unchanged, out_valid=0.
  - Assert rst_n=0 asynchronously mid-stream → sum=0 and out_valid=0 immediately.
  - Four back-to-back valid inputs → four consecutive correct outputs.
